// File: rtl/serial_subtract.sv
// Bit-serial WIDTH-bit subtractor (result = a - b - bin) driving a single full_subtract cell.
// Optional macro SERIAL_SUB_CLAMP_EN: saturate result to zero when the final borrow is set.

module full_subtract (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);
    assign d    = a ^ b ^ bin;
    assign bout = (~a & b) | (~(a ^ b) & bin);
endmodule

module serial_subtract #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             bout
);
    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state_r;
    state_t           state_s;
    logic [WIDTH-1:0] a_sh_r;
    logic [WIDTH-1:0] b_sh_r;
    logic [WIDTH-1:0] result_r;
    logic [CNT_W-1:0] cnt_r;
    logic             borrow_r;
    logic             bout_r;
    logic             busy_r;
    logic             done_r;
    logic             accept_s;
    logic             last_s;
    logic             cell_d_s;
    logic             cell_bout_s;

    full_subtract u_cell (
        .a    (a_sh_r[0]),
        .b    (b_sh_r[0]),
        .bin  (borrow_r),
        .d    (cell_d_s),
        .bout (cell_bout_s)
    );

    assign last_s = (cnt_r == LAST_CNT);

    // Next-state decode and start acceptance (IDLE and DONE both accept).
    always_comb begin
        state_s  = state_r;
        accept_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (start) begin
                    accept_s = 1'b1;
                    state_s  = SHIFT;
                end else begin
                    state_s  = IDLE;
                end
            end
            SHIFT: begin
                if (last_s) begin
                    state_s = DONE;
                end else begin
                    state_s = SHIFT;
                end
            end
            DONE: begin
                if (start) begin
                    accept_s = 1'b1;
                    state_s  = SHIFT;
                end else begin
                    state_s  = IDLE;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State register with registered busy/done flags derived from the next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            busy_r  <= (state_s == SHIFT);
            done_r  <= (state_s == DONE);
        end
    end

    // Operand shift registers, borrow chain, bit counter and result capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_sh_r   <= '0;
            b_sh_r   <= '0;
            borrow_r <= 1'b0;
            cnt_r    <= '0;
            result_r <= '0;
            bout_r   <= 1'b0;
        end else if (accept_s) begin
            a_sh_r   <= a;
            b_sh_r   <= b;
            borrow_r <= bin;
            cnt_r    <= '0;
            result_r <= '0;
        end else if (state_r == SHIFT) begin
            a_sh_r   <= {1'b0, a_sh_r[WIDTH-1:1]};
            b_sh_r   <= {1'b0, b_sh_r[WIDTH-1:1]};
            borrow_r <= cell_bout_s;
            cnt_r    <= cnt_r + 1'b1;
`ifdef SERIAL_SUB_CLAMP_EN
            // Underflow on the last bit saturates the difference at zero.
            if (last_s && cell_bout_s) begin
                result_r <= '0;
            end else begin
                result_r <= {cell_d_s, result_r[WIDTH-1:1]};
            end
`else
            result_r <= {cell_d_s, result_r[WIDTH-1:1]};
`endif
            if (last_s) begin
                bout_r <= cell_bout_s;
            end else begin
                bout_r <= bout_r;
            end
        end else begin
            result_r <= result_r;
            bout_r   <= bout_r;
        end
    end

    assign busy   = busy_r;
    assign done   = done_r;
    assign result = result_r;
    assign bout   = bout_r;

endmodule

// File: tb/tb_serial_subtract.sv
// Self-checking bench for serial_subtract: directed literal cases plus randomized traffic
// compared every cycle against a cycle-count/arithmetic model.

module tb_serial_subtract;
    localparam int W = 8;
`ifdef SERIAL_SUB_CLAMP_EN
    localparam bit CLAMP = 1'b1;
`else
    localparam bit CLAMP = 1'b0;
`endif

    logic         clk;
    logic         rst;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         bin;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic         bout;

    int vectors;
    int miscompares;

    serial_subtract #(.WIDTH(W)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .a      (a),
        .b      (b),
        .bin    (bin),
        .busy   (busy),
        .done   (done),
        .result (result),
        .bout   (bout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // Reference model: an op occupies W busy cycles then one done cycle.
    int           rem;
    bit           model_on;
    logic         m_busy, m_done, m_bout, pend_bo;
    logic [W-1:0] m_result, pend_r;

    initial begin
        rem = 0; model_on = 1'b0;
        m_busy = 1'b0; m_done = 1'b0; m_bout = 1'b0; m_result = '0;
        pend_r = '0; pend_bo = 1'b0;
    end

    always @(posedge clk) begin
        bit acc;
        if (rst) begin
            rem = 0; model_on = 1'b1;
            m_busy = 1'b0; m_done = 1'b0; m_result = '0; m_bout = 1'b0;
        end else begin
            acc = start && (rem <= 1);
            if (rem > 0) rem--;
            if (acc) begin
                rem     = W + 1;
                pend_r  = W'(int'(a) - int'(b) - int'(bin));
                pend_bo = (int'(a) < int'(b) + int'(bin));
                if (CLAMP && pend_bo) pend_r = '0;
            end
            m_busy = (rem >= 2);
            m_done = (rem == 1);
            if (m_done) begin
                m_result = pend_r;
                m_bout   = pend_bo;
            end
        end
    end

    always @(negedge clk) begin
        if (model_on) begin
            chk("busy", 32'(busy), 32'(m_busy));
            chk("done", 32'(done), 32'(m_done));
            if (!m_busy) begin
                chk("result", 32'(result), 32'(m_result));
                chk("bout", 32'(bout), 32'(m_bout));
            end
        end
    end

    task automatic start_op(input logic [W-1:0] av, input logic [W-1:0] bv, input logic bi);
        @(negedge clk);
        a = av; b = bv; bin = bi; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int n0, output int n);
        n = n0;
        while (done !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (done !== 1'b1) begin
            vectors++;
            miscompares++;
            $display("FAIL done_timeout: no done after %0d cycles", n);
        end
    endtask

    task automatic run_op(input string name, input logic [W-1:0] av, input logic [W-1:0] bv,
                          input logic bi, input logic [W-1:0] er, input logic eb);
        int n;
        start_op(av, bv, bi);
        wait_done(1, n);
        chk({name, "_lat"}, 32'(n), 32'(W + 1));
        chk({name, "_res"}, 32'(result), 32'(er));
        chk({name, "_bout"}, 32'(bout), 32'(eb));
    endtask

    initial begin
        int n;
        int busy_cnt;
        int done_cnt;
        vectors = 0; miscompares = 0;
        rst = 1'b1; start = 1'b0; a = '0; b = '0; bin = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_result", 32'(result), 32'd0);
        chk("rst_bout", 32'(bout), 32'd0);
        rst = 1'b0;

        // Basic op with busy-length check.
        start_op(8'h5A, 8'h23, 1'b0);
        busy_cnt = 0;
        n = 1;
        while (done !== 1'b1 && n < 40) begin
            if (busy === 1'b1) busy_cnt++;
            @(negedge clk);
            n++;
        end
        chk("t1_busy_cycles", 32'(busy_cnt), 32'd8);
        chk("t1_lat", 32'(n), 32'd9);
        chk("t1_res", 32'(result), 32'h37);
        chk("t1_bout", 32'(bout), 32'd0);

        run_op("t2", 8'h10, 8'h20, 1'b0, CLAMP ? 8'h00 : 8'hF0, 1'b1);
        run_op("t3", 8'h00, 8'h00, 1'b1, CLAMP ? 8'h00 : 8'hFF, 1'b1);

        // Start while busy must be ignored.
        start_op(8'hFF, 8'h01, 1'b0);
        @(negedge clk);
        a = 8'h00; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(3, n);
        chk("t4_lat", 32'(n), 32'd9);
        chk("t4_res", 32'(result), 32'hFE);
        chk("t4_bout", 32'(bout), 32'd0);

        // Reset mid-shift aborts without a done pulse.
        start_op(8'h80, 8'h01, 1'b0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("t5_busy", 32'(busy), 32'd0);
        chk("t5_result", 32'(result), 32'd0);
        chk("t5_bout", 32'(bout), 32'd0);
        done_cnt = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done === 1'b1) done_cnt++;
        end
        chk("t5_no_done", 32'(done_cnt), 32'd0);
        run_op("t5b", 8'h80, 8'h01, 1'b0, 8'h7F, 1'b0);

        // Start accepted in the DONE cycle.
        start_op(8'h5A, 8'h23, 1'b0);
        wait_done(1, n);
        chk("t6a_lat", 32'(n), 32'd9);
        chk("t6a_res", 32'(result), 32'h37);
        a = 8'h03; b = 8'h05; bin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(1, n);
        chk("t6b_lat", 32'(n), 32'd9);
        chk("t6b_res", 32'(result), CLAMP ? 32'h00 : 32'hFE);
        chk("t6b_bout", 32'(bout), 32'd1);

        // Randomized traffic checked by the model every cycle.
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            rst   = ($urandom_range(0, 199) == 0);
            start = ($urandom_range(0, 3) == 0);
            a     = W'($urandom);
            b     = W'($urandom);
            bin   = 1'($urandom_range(0, 1));
        end
        @(negedge clk);
        rst = 1'b0; start = 1'b0;
        repeat (12) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/serial_subtract.md
Name: serial_subtract

Overview:
- Bit-serial N-bit subtractor built around one full_subtract cell: result = A - B - Bin.
- Sits directly upstream of full_subtract and drives it. Each cycle it feeds one operand bit pair plus the registered borrow into the cell, then captures D and Bout.
- Trades a WIDTH-cycle latency for a single subtractor cell. Training-board consumer of the full-subtractor stage.

Parameters:
- WIDTH, 8, operand/result width in bits; legal range 2..32.

Ports:
- clk  input  1  system clock, all state on rising edge
- rst  input  1  synchronous, active-high reset
- start  input  1  request pulse; sampled only in IDLE or DONE
- a  input  WIDTH  minuend, latched on accepted start
- b  input  WIDTH  subtrahend, latched on accepted start
- bin  input  1  borrow-in, latched on accepted start
- busy  output  1  high while shifting
- done  output  1  one-cycle pulse when result/bout are valid
- result  output  WIDTH  difference, held until the next accepted start
- bout  output  1  final borrow-out, held with result

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Reset (rst=1 at a clk edge): state=IDLE; busy=0, done=0, result=0, bout=0; internal shift regs, borrow reg and bit counter cleared.
- States: IDLE, SHIFT, DONE.
- IDLE: start=1 -> latch a, b into shift regs, borrow_r<=bin, cnt<=0, result<=0, go SHIFT.
- SHIFT, each cycle:
  - full_subtract inputs: A=a_sh[0], B=b_sh[0], Bin=borrow_r.
  - result<={D, result[WIDTH-1:1]} (LSB-first in, right-shift).
  - a_sh, b_sh shift right 1; borrow_r<=Bout; cnt<=cnt+1.
  - When cnt==WIDTH-1, go DONE with bout<=Bout of that final bit.
- busy=1 exactly during the WIDTH SHIFT cycles.
- DONE: done=1 for this single cycle, then go IDLE; result/bout remain stable.
- Latency: start sampled at edge k -> done high in the cycle after edge k+WIDTH. Cycle k+WIDTH+1 relative to start is the next acceptance point.
- start while busy=1: ignored. No queuing; a, b, bin changes have no effect.
- start in DONE cycle: accepted like IDLE. Back-to-back ops at one per WIDTH+1 cycles; done still pulses for the finished op.
- Arithmetic is modulo 2^WIDTH: bout=1 iff a < b+bin (unsigned).
- rst mid-SHIFT: aborts immediately, all outputs to reset values, no done pulse.
- Counter width clog2(WIDTH); no wrap-around beyond WIDTH-1 is possible.

Optional Feature:
- Macro: SERIAL_SUB_CLAMP_EN.
- Defined: on entry to DONE, if final borrow=1, result is forced to 0 (unsigned saturation); bout still reports 1.
- Undefined: result is the raw modulo-2^WIDTH difference; no clamp logic.

Test Plan:
- WIDTH=8, a=0x5A, b=0x23, bin=0, start -> busy for 8 cycles, done at cycle 9, result=0x37, bout=0.
- a=0x10, b=0x20, bin=0 -> result=0xF0, bout=1. With SERIAL_SUB_CLAMP_EN: result=0x00, bout=1.
- a=0x00, b=0x00, bin=1 -> result=0xFF, bout=1 (borrow ripples all 8 bits).
- Start a=0xFF, b=0x01; pulse start again with a=0x00 at cycle 3 -> second start ignored, result=0xFE, bout=0.
- Start a=0x80, b=0x01; assert rst at cycle 4 -> next cycle busy=0, result=0, bout=0, no done; then a=0x80, b=0x01 gives result=0x7F.
- Assert start in the DONE cycle with a=0x03, b=0x05 -> first op's done seen, second op yields result=0xFE, bout=1 exactly 9 cycles later.
